// File: rtl/pool_2_ctrl.sv
// pool_2_ctrl: layer-2 max-pool sequencer; paired row reads from fm_bram_1, one pooled-row write to fm_bram_0 per read pair.
module pool_2_ctrl #(
  parameter int OUT_ROWS = 5,
  parameter int LANES    = 64,
  parameter int DW       = 16,
  parameter int RD_LAT   = 2,
  parameter int POOL_LAT = 1,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pool_2_en,
  input  logic [LANES*DW-1:0]   pool_max_result,
  output logic                  fm_bram_1_ena,
  output logic                  fm_bram_1_enb,
  output logic [6:0]            fm_bram_1_addra,
  output logic [6:0]            fm_bram_1_addrb,
  output logic                  fm_bram_0_wea,
  output logic [5:0]            fm_bram_0_addra,
  output logic [LANES*DW-1:0]   fm_bram_0_dina,
  output logic                  pool_2_busy,
  output logic                  pool_2_finish
);
  localparam int LAT = RD_LAT + POOL_LAT;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t         state;
  logic [6:0]     rd_cnt, wr_cnt, rd_addr;
  logic [LAT-1:0] vld;
  assign rd_addr = 7'(IN_BASE) + {rd_cnt[5:0], 1'b0};
  // The first row is issued on the IDLE exit edge, so rd_cnt leaves IDLE already pointing at row 1.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= IDLE;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      vld             <= '0;
      fm_bram_1_ena   <= 1'b0;
      fm_bram_1_enb   <= 1'b0;
      fm_bram_1_addra <= '0;
      fm_bram_1_addrb <= '0;
      fm_bram_0_wea   <= 1'b0;
      fm_bram_0_addra <= '0;
      fm_bram_0_dina  <= '0;
      pool_2_busy     <= 1'b0;
      pool_2_finish   <= 1'b0;
    end else begin
      vld           <= LAT'({vld, fm_bram_1_ena});
      fm_bram_0_wea <= vld[LAT-1];
      if (vld[LAT-1]) begin
        fm_bram_0_addra <= 6'(OUT_BASE) + wr_cnt[5:0];
        fm_bram_0_dina  <= pool_max_result;
        wr_cnt          <= wr_cnt + 7'd1;
      end
      unique case (state)
        IDLE: if (pool_2_en) begin
          state           <= ISSUE;
          fm_bram_1_ena   <= 1'b1;
          fm_bram_1_enb   <= 1'b1;
          fm_bram_1_addra <= 7'(IN_BASE);
          fm_bram_1_addrb <= 7'(IN_BASE) + 7'd1;
          rd_cnt          <= 7'd1;
          wr_cnt          <= '0;
          pool_2_busy     <= 1'b1;
        end
        ISSUE: if (rd_cnt == 7'(OUT_ROWS)) begin
          state         <= DRAIN;
          fm_bram_1_ena <= 1'b0;
          fm_bram_1_enb <= 1'b0;
        end else begin
          fm_bram_1_addra <= rd_addr;
          fm_bram_1_addrb <= rd_addr + 7'd1;
          rd_cnt          <= rd_cnt + 7'd1;
        end
        // wr_cnt has already advanced past the final row while its write is on the port
        DRAIN: if (fm_bram_0_wea && wr_cnt == 7'(OUT_ROWS)) begin
          state         <= DONE;
          pool_2_busy   <= 1'b0;
          pool_2_finish <= 1'b1;
        end
        DONE: begin
          state         <= IDLE;
          pool_2_finish <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_pool_2_ctrl.sv
// tb_pool_2_ctrl: scoreboard bench; two instances (default and single-row/offset) against an event-list reference model.
module tb_pool_2_ctrl;
  localparam int L = 3;
  typedef struct {int d; int cyc; int a; int b;} ev_t;
  logic          clk = 1'b0;
  logic [1:0]    rstv = 2'b00, env = 2'b00;
  logic [1023:0] pool = '0;
  logic [1:0]    ea, eb, we, bu, fi;
  logic [6:0]    aa[2], ab[2];
  logic [5:0]    wa[2];
  logic [1023:0] di[2];
  logic [1023:0] hist[2048];
  ev_t rq[$], wq[$], fq[$];
  int cyc = -1, errors = 0, checks = 0;
  int idle_from[2] = '{1 << 30, 1 << 30};
  int blo[2] = '{0, 0}, bhi[2] = '{-1, -1};

  always #5 clk = ~clk;

  pool_2_ctrl u0 (
    .clk(clk), .rst(rstv[0]), .pool_2_en(env[0]), .pool_max_result(pool),
    .fm_bram_1_ena(ea[0]), .fm_bram_1_enb(eb[0]), .fm_bram_1_addra(aa[0]), .fm_bram_1_addrb(ab[0]),
    .fm_bram_0_wea(we[0]), .fm_bram_0_addra(wa[0]), .fm_bram_0_dina(di[0]),
    .pool_2_busy(bu[0]), .pool_2_finish(fi[0]));

  pool_2_ctrl #(.OUT_ROWS(1), .IN_BASE(10), .OUT_BASE(3)) u1 (
    .clk(clk), .rst(rstv[1]), .pool_2_en(env[1]), .pool_max_result(pool),
    .fm_bram_1_ena(ea[1]), .fm_bram_1_enb(eb[1]), .fm_bram_1_addra(aa[1]), .fm_bram_1_addrb(ab[1]),
    .fm_bram_0_wea(we[1]), .fm_bram_0_addra(wa[1]), .fm_bram_0_dina(di[1]),
    .pool_2_busy(bu[1]), .pool_2_finish(fi[1]));

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  // A pass started at cycle c: row r read in c+1+r, its pooled data valid in c+1+r+L, written in c+2+r+L.
  task automatic start(input int d, input int c);
    int n, ib, ob;
    n = d ? 1 : 5;
    ib = d ? 10 : 0;
    ob = d ? 3 : 0;
    for (int r = 0; r < n; r++) begin
      rq.push_back('{d, c + 1 + r, (ib + 2 * r) % 128, (ib + 2 * r + 1) % 128});
      wq.push_back('{d, c + r + L + 2, (ob + r) % 64, c + 1 + r + L});
    end
    fq.push_back('{d, c + n + L + 2, 0, 0});
    blo[d] = c + 1;
    bhi[d] = c + n + L + 1;
    idle_from[d] = c + n + L + 3;
  endtask

  task automatic flush(input int d);
    for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].d == d) rq.delete(k);
    for (int k = wq.size() - 1; k >= 0; k--) if (wq[k].d == d) wq.delete(k);
    for (int k = fq.size() - 1; k >= 0; k--) if (fq[k].d == d) fq.delete(k);
    idle_from[d] = 1 << 30;
    bhi[d] = -1;
  endtask

  task automatic mon(input int d);
    int i, ln;
    logic due;
    if (!rstv[d]) begin
      check($sformatf("rst_outs%0d", d), 64'({ea[d], eb[d], aa[d], ab[d], we[d], wa[d], bu[d], fi[d]}), 64'd0);
      check($sformatf("rst_dina%0d", d), 64'(|di[d]), 64'd0);
    end else begin
      i = -1;
      foreach (rq[k]) if (i < 0 && rq[k].d == d) i = k;
      due = i >= 0 && rq[i].cyc == cyc;
      check($sformatf("rd_en%0d", d), 64'({ea[d], eb[d]}), due ? 64'd3 : 64'd0);
      if (due) begin
        check($sformatf("addra%0d", d), 64'(aa[d]), 64'(rq[i].a));
        check($sformatf("addrb%0d", d), 64'(ab[d]), 64'(rq[i].b));
        rq.delete(i);
      end
      i = -1;
      foreach (wq[k]) if (i < 0 && wq[k].d == d) i = k;
      due = i >= 0 && wq[i].cyc == cyc;
      check($sformatf("wea%0d", d), 64'(we[d]), 64'(due));
      if (due) begin
        check($sformatf("waddr%0d", d), 64'(wa[d]), 64'(wq[i].a));
        ln = -1;
        for (int k = 0; k < 64; k++)
          if (ln < 0 && di[d][k*16+:16] !== hist[wq[i].b][k*16+:16]) ln = k;
        if (ln < 0) ln = 0;
        check($sformatf("dina%0d_lane%0d", d, ln), 64'(di[d][ln*16+:16]), 64'(hist[wq[i].b][ln*16+:16]));
        wq.delete(i);
      end
      i = -1;
      foreach (fq[k]) if (i < 0 && fq[k].d == d) i = k;
      due = i >= 0 && fq[i].cyc == cyc;
      check($sformatf("finish%0d", d), 64'(fi[d]), 64'(due));
      if (due) fq.delete(i);
      check($sformatf("busy%0d", d), 64'(bu[d]), 64'(cyc >= blo[d] && cyc <= bhi[d]));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cyc >= 0) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    for (int c = 0; c < 900; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      for (int k = 0; k < 32; k++) pool[k*32+:32] = $urandom;
      hist[c] = pool;
      if (c == 3) begin
        rstv = 2'b11;
        idle_from = '{3, 3};
      end
      if (c == 37 || c == 500) begin
        rstv[0] = 1'b0;
        flush(0);
      end
      if (c == 39 || c == 502) begin
        rstv[0] = 1'b1;
        idle_from[0] = c;
      end
      env[0] = (c == 5 || c == 8 || c == 15 || c == 16 || c == 30 || c == 41) ||
               (c >= 60 && c < 850 && $urandom_range(0, 4) == 0);
      env[1] = c == 5 || (c >= 60 && c < 850 && $urandom_range(0, 3) == 0);
      for (int d = 0; d < 2; d++)
        if (env[d] && rstv[d] && c >= idle_from[d]) start(d, c);
    end
    @(posedge clk);
    #1;
    check("reads_left", 64'(rq.size()), 64'd0);
    check("writes_left", 64'(wq.size()), 64'd0);
    check("finish_left", 64'(fq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
